// File: rtl/core_operand_fwd_stage.sv
// ID->EX operand register with forwarding, use-before-ready hazard stalls and a
// saturating stall counter.
module core_operand_fwd_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REG_IDX_W   = 5,
  parameter int unsigned NUM_FWD     = 2,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           id_valid,
  output logic                           id_ready,
  input  logic [REG_IDX_W-1:0]           id_ra_idx,
  input  logic [REG_IDX_W-1:0]           id_rb_idx,
  input  logic                           id_ra_used,
  input  logic                           id_rb_used,
  input  logic [DATA_W-1:0]              rega_data,
  input  logic [DATA_W-1:0]              regb_data,
  input  logic [DATA_W-1:0]              imm,
  input  logic [ADDR_W-1:0]              id_pc,
  input  logic [1:0]                     opmux_a,
  input  logic [1:0]                     opmux_b,
  input  logic [NUM_FWD-1:0]             fwd_valid,
  input  logic [NUM_FWD-1:0]             fwd_pending,
  input  logic [NUM_FWD*REG_IDX_W-1:0]   fwd_idx,
  input  logic [NUM_FWD*DATA_W-1:0]      fwd_data,
  output logic                           ex_valid,
  input  logic                           ex_ready,
  output logic [DATA_W-1:0]              operand_a,
  output logic [DATA_W-1:0]              operand_b,
  output logic [STALL_CNT_W-1:0]         stall_cnt
);

  logic                   ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0]      operand_a_q, operand_a_d;
  logic [DATA_W-1:0]      operand_b_q, operand_b_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic              a_hit, b_hit, a_pend, b_pend;
  logic [DATA_W-1:0] a_res, b_res, pc_ext;
  logic              hazard, capture;

  // Zero-extends or truncates depending on the relative widths.
  assign pc_ext = DATA_W'(id_pc);

  // Ascending scan with a first-hit latch so the youngest (lowest k) source wins.
  always_comb begin
    a_hit  = 1'b0;
    b_hit  = 1'b0;
    a_pend = 1'b0;
    b_pend = 1'b0;
    a_res  = rega_data;
    b_res  = regb_data;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (!a_hit && id_ra_used && (id_ra_idx != '0) && fwd_valid[k] &&
          (fwd_idx[k*REG_IDX_W +: REG_IDX_W] == id_ra_idx)) begin
        a_hit  = 1'b1;
        a_pend = fwd_pending[k];
        a_res  = fwd_data[k*DATA_W +: DATA_W];
      end
      if (!b_hit && id_rb_used && (id_rb_idx != '0) && fwd_valid[k] &&
          (fwd_idx[k*REG_IDX_W +: REG_IDX_W] == id_rb_idx)) begin
        b_hit  = 1'b1;
        b_pend = fwd_pending[k];
        b_res  = fwd_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign hazard   = id_valid && (a_pend || b_pend);
  assign id_ready = !hazard && !flush && (!ex_valid_q || ex_ready);
  assign capture  = id_valid && id_ready;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (capture) begin
      ex_valid_d = 1'b1;
      unique case (opmux_a)
        2'd0:    operand_a_d = a_res;
        2'd1:    operand_a_d = pc_ext;
        default: operand_a_d = '0;
      endcase
      unique case (opmux_b)
        2'd0:    operand_b_d = b_res;
        2'd1:    operand_b_d = imm;
        2'd2:    operand_b_d = pc_ext;
        default: operand_b_d = '0;
      endcase
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q  <= 1'b0;
      operand_a_q <= '0;
      operand_b_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign operand_a = operand_a_q;
  assign operand_b = operand_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_core_operand_fwd_stage.sv
// Directed bench for core_operand_fwd_stage; a second instance with a 2-bit stall
// counter shares all inputs to exercise saturation.
module tb_core_operand_fwd_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, id_valid, id_ready, id_ready2;
  logic [4:0]  id_ra_idx, id_rb_idx;
  logic        id_ra_used, id_rb_used;
  logic [31:0] rega_data, regb_data, imm, id_pc;
  logic [1:0]  opmux_a, opmux_b;
  logic [1:0]  fwd_valid, fwd_pending;
  logic [9:0]  fwd_idx;
  logic [63:0] fwd_data;
  logic        ex_valid, ex_valid2, ex_ready;
  logic [31:0] operand_a, operand_b, operand_a2, operand_b2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_operand_fwd_stage u_dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx), .id_ra_used(id_ra_used),
    .id_rb_used(id_rb_used), .rega_data(rega_data), .regb_data(regb_data), .imm(imm),
    .id_pc(id_pc), .opmux_a(opmux_a), .opmux_b(opmux_b), .fwd_valid(fwd_valid),
    .fwd_pending(fwd_pending), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .operand_a(operand_a),
    .operand_b(operand_b), .stall_cnt(stall_cnt)
  );

  core_operand_fwd_stage #(.STALL_CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready2),
    .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx), .id_ra_used(id_ra_used),
    .id_rb_used(id_rb_used), .rega_data(rega_data), .regb_data(regb_data), .imm(imm),
    .id_pc(id_pc), .opmux_a(opmux_a), .opmux_b(opmux_b), .fwd_valid(fwd_valid),
    .fwd_pending(fwd_pending), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
    .ex_valid(ex_valid2), .ex_ready(ex_ready), .operand_a(operand_a2),
    .operand_b(operand_b2), .stall_cnt(stall_cnt2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 0; id_valid = 0; id_ra_idx = 0; id_rb_idx = 0; id_ra_used = 0; id_rb_used = 0;
    rega_data = 0; regb_data = 0; imm = 0; id_pc = 0; opmux_a = 0; opmux_b = 0;
    fwd_valid = 0; fwd_pending = 0; fwd_idx = 0; fwd_data = 0; ex_ready = 1;
    #1 rst = 1'b0;
    #2;
    check_eq("rst_ex_valid", 64'(ex_valid), 64'd0);
    check_eq("rst_op_a", 64'(operand_a), 64'd0);
    check_eq("rst_op_b", 64'(operand_b), 64'd0);
    check_eq("rst_stall", 64'(stall_cnt), 64'd0);
    @(negedge clk) rst = 1'b1;
    step();

    // Basic capture, no forwarding hits
    id_valid = 1; id_ra_idx = 3; id_ra_used = 1; rega_data = 32'h11;
    imm = 32'h5; opmux_a = 2'd0; opmux_b = 2'd1;
    #1 check_eq("t1_id_ready", 64'(id_ready), 64'd1);
    step();
    check_eq("t1_ex_valid", 64'(ex_valid), 64'd1);
    check_eq("t1_op_a", 64'(operand_a), 64'h11);
    check_eq("t1_op_b", 64'(operand_b), 64'h5);

    // Forward priority
    fwd_valid = 2'b11; fwd_idx = {5'd3, 5'd3}; fwd_data = {32'hBB, 32'hAA};
    step();
    check_eq("fwd_youngest", 64'(operand_a), 64'hAA);
    fwd_valid = 2'b10;
    step();
    check_eq("fwd_src1", 64'(operand_a), 64'hBB);
    id_ra_idx = 0; fwd_valid = 2'b11; fwd_idx = {5'd0, 5'd0}; rega_data = 32'h22;
    step();
    check_eq("fwd_r0_regfile", 64'(operand_a), 64'h22);

    // Pending hazard on rb for 3 cycles
    id_ra_used = 0; rega_data = 32'h33; id_rb_used = 1; id_rb_idx = 7; regb_data = 32'h99;
    opmux_b = 2'd0; fwd_valid = 2'b01; fwd_idx = {5'd0, 5'd7}; fwd_pending = 2'b01;
    fwd_data = {32'h0, 32'h77};
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("haz_id_ready", 64'(id_ready), 64'd0);
      step();
      check_eq("haz_stall", 64'(stall_cnt), 64'(i + 1));
    end
    check_eq("haz_drained", 64'(ex_valid), 64'd0);
    check_eq("haz_stall_sat_inst", 64'(stall_cnt2), 64'd3);
    fwd_pending = 2'b00;
    #1 check_eq("haz_release_ready", 64'(id_ready), 64'd1);
    step();
    check_eq("haz_op_b", 64'(operand_b), 64'h77);
    check_eq("haz_op_a", 64'(operand_a), 64'h33);
    check_eq("haz_ex_valid", 64'(ex_valid), 64'd1);
    check_eq("haz_stall_final", 64'(stall_cnt), 64'd3);

    // Hold with ex_ready low while inputs change
    ex_ready = 0;
    for (int i = 0; i < 4; i++) begin
      rega_data = 32'h44 + 32'(i); regb_data = 32'h55 + 32'(i); fwd_data = {32'h0, 32'h88};
      #1 check_eq("hold_id_ready", 64'(id_ready), 64'd0);
      step();
      check_eq("hold_ex_valid", 64'(ex_valid), 64'd1);
      check_eq("hold_op_a", 64'(operand_a), 64'h33);
      check_eq("hold_op_b", 64'(operand_b), 64'h77);
    end

    // Back-to-back transfers, PC and zero selections
    ex_ready = 1; fwd_valid = 0; opmux_a = 2'd1; opmux_b = 2'd3; id_pc = 32'h1000;
    #1 check_eq("b2b_id_ready", 64'(id_ready), 64'd1);
    step();
    check_eq("b2b1_valid", 64'(ex_valid), 64'd1);
    check_eq("b2b1_op_a_pc", 64'(operand_a), 64'h1000);
    check_eq("b2b1_op_b_zero", 64'(operand_b), 64'h0);
    opmux_a = 2'd3; opmux_b = 2'd2; id_pc = 32'h2000;
    step();
    check_eq("b2b2_valid", 64'(ex_valid), 64'd1);
    check_eq("b2b2_op_a_rsvd", 64'(operand_a), 64'h0);
    check_eq("b2b2_op_b_pc", 64'(operand_b), 64'h2000);

    // Flush beats hold and capture
    ex_ready = 0; flush = 1; opmux_a = 2'd0; rega_data = 32'h66;
    #1 check_eq("flush_id_ready", 64'(id_ready), 64'd0);
    step();
    check_eq("flush_ex_valid", 64'(ex_valid), 64'd0);
    check_eq("flush_no_capture", 64'(operand_a), 64'h0);
    // Hazard during flush is not counted
    fwd_valid = 2'b01; fwd_pending = 2'b01;
    step();
    check_eq("flush_haz_stall", 64'(stall_cnt), 64'd3);
    flush = 0; fwd_valid = 0; fwd_pending = 0;

    // Reset in the middle of a hold
    ex_ready = 1; rega_data = 32'h12;
    step();
    check_eq("pre_rst_valid", 64'(ex_valid), 64'd1);
    check_eq("pre_rst_op_a", 64'(operand_a), 64'h12);
    ex_ready = 0;
    step();
    step();
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_ex_valid", 64'(ex_valid), 64'd0);
    check_eq("midrst_op_a", 64'(operand_a), 64'd0);
    check_eq("midrst_op_b", 64'(operand_b), 64'd0);
    check_eq("midrst_stall", 64'(stall_cnt), 64'd0);
    id_valid = 0;
    @(negedge clk) rst = 1'b1;
    step();

    // Saturation of the 2-bit counter over 5 hazard cycles
    id_valid = 1; ex_ready = 1; id_rb_used = 1; id_rb_idx = 7;
    fwd_valid = 2'b01; fwd_idx = {5'd0, 5'd7}; fwd_pending = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("sat_stall2", 64'(stall_cnt2), 64'((i + 1 > 3) ? 3 : i + 1));
      check_eq("sat_stall16", 64'(stall_cnt), 64'(i + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
